// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: op and state encodings shared by the shift sequencer and its stage.
package shift_seq_pkg;
    typedef enum logic [1:0] {OP_ROL = 2'b00, OP_SLL = 2'b01, OP_ROR = 2'b10, OP_SRL = 2'b11} op_t;
    typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_SHIFT = 2'b01, ST_DONE = 2'b10} state_t;
endpackage

// File: rtl/shift_seq_stage.sv
// shift_stage: one power-of-two (2^amt_sel) rotate/shift of in; passes in through when en=0.
module shift_stage
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4,
    parameter int K_W   = 2
) (
    input  logic [WIDTH-1:0] in,
    input  op_t              op,
    input  logic [K_W-1:0]   amt_sel,
    input  logic             en,
    output logic [WIDTH-1:0] out
);
    logic [CNT_W-1:0]   amt;
    logic [2*WIDTH-1:0] rl, rr;
    assign amt = CNT_W'(1) << amt_sel;
    // Rotates come from shifting the operand concatenated with itself.
    assign rl  = {in, in} << amt;
    assign rr  = {in, in} >> amt;
    assign out = !en           ? in :
                 op == OP_ROL  ? rl[2*WIDTH-1:WIDTH] :
                 op == OP_ROR  ? rr[WIDTH-1:0] :
                 op == OP_SLL  ? in << amt : in >> amt;
endmodule

// File: rtl/shift_seq.sv
// shift_seq: multi-cycle rotate/shift sequencer applying one power-of-two stage per clock.
// Define SHIFT_SEQ_EARLY_DONE_EN to visit only the set bits of cnt (early done).
module shift_seq
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [CNT_W-1:0] cnt,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done
);
    localparam int K_W = CNT_W > 1 ? $clog2(CNT_W) : 1;
    state_t           state, next;
    logic [WIDTH-1:0] data, stage_out;
    logic [CNT_W-1:0] rem, rem_next;
    op_t              op_q;
    logic [K_W-1:0]   sel;
    logic             en, last, skip;
`ifdef SHIFT_SEQ_EARLY_DONE_EN
    always_comb begin
        sel = '0;
        for (int i = CNT_W - 1; i >= 0; i--)
            if (rem[i]) sel = K_W'(i);
    end
    assign en       = |rem;
    assign rem_next = rem & (rem - CNT_W'(1));
    assign last     = rem_next == '0;
    assign skip     = cnt == '0;
`else
    logic [K_W-1:0] k;
    assign sel      = k;
    assign en       = rem[k];
    assign rem_next = rem;
    assign last     = k == K_W'(CNT_W - 1);
    assign skip     = 1'b0;
    always_ff @(posedge clk or posedge rst)
        if (rst) k <= '0;
        else k <= state == ST_SHIFT ? k + K_W'(1) : '0;
`endif
    shift_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W), .K_W(K_W)) u_stage (
        .in(data), .op(op_q), .amt_sel(sel), .en(en), .out(stage_out)
    );
    always_comb begin
        next = state == ST_IDLE  ? (start ? (skip ? ST_DONE : ST_SHIFT) : ST_IDLE) :
               state == ST_SHIFT ? (last ? ST_DONE : ST_SHIFT) : ST_IDLE;
    end
    // busy/done are flopped from next so they carry no input-to-output path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            data  <= '0;
            rem   <= '0;
            op_q  <= OP_ROL;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next;
            busy  <= next != ST_IDLE;
            done  <= next == ST_DONE;
            if (state == ST_IDLE && start) begin
                data <= in;
                rem  <= cnt;
                op_q <= op_t'(op);
            end else if (state == ST_SHIFT) begin
                data <= stage_out;
                rem  <= rem_next;
            end
        end
    end
    assign out = data;
endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: directed self-checking bench for shift_seq (both SHIFT_SEQ_EARLY_DONE_EN builds).
module tb_shift_seq;
    import shift_seq_pkg::*;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [15:0] in_v = '0, out_v;
    logic [3:0]  cnt_v = '0;
    logic [1:0]  op_v = '0;
    logic        busy, done;
    int          checks = 0, errors = 0;

    shift_seq dut (
        .clk(clk), .rst(rst), .start(start), .in(in_v), .cnt(cnt_v), .op(op_v),
        .out(out_v), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic int exp_lat(input logic [3:0] c);
`ifdef SHIFT_SEQ_EARLY_DONE_EN
        return $countones(c);
`else
        return 4;
`endif
    endfunction

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_v !== 16'h0) begin errors++; $display("FAIL reset_out got=%h exp=0000", out_v); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic run(input logic [15:0] a, input logic [3:0] c, input logic [1:0] o,
                       input logic [15:0] exp, input string name);
        int n;
        @(negedge clk); in_v = a; cnt_v = c; op_v = o; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; in_v = ~a; cnt_v = ~c; op_v = ~o;
        n = 0;
        while (!done && n < 20) begin @(posedge clk); #1; n++; end
        checks++; if (n != exp_lat(c)) begin errors++; $display("FAIL %s_latency got=%0d exp=%0d", name, n, exp_lat(c)); end
        checks++; if (out_v !== exp) begin errors++; $display("FAIL %s_out got=%h exp=%h", name, out_v, exp); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy_at_done got=%b exp=1", name, busy); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s_idle got done=%b busy=%b exp 0 0", name, done, busy); end
        checks++; if (out_v !== exp) begin errors++; $display("FAIL %s_hold got=%h exp=%h", name, out_v, exp); end
    endtask

    task automatic test_ops();
        run(16'h8001, 4'd1,  OP_ROL, 16'h0003, "rol_8001_1");
        run(16'h00FF, 4'd4,  OP_SLL, 16'h0FF0, "sll_00ff_4");
        run(16'h0001, 4'd15, OP_ROR, 16'h0002, "ror_0001_15");
        run(16'h8000, 4'd15, OP_SRL, 16'h0001, "srl_8000_15");
        run(16'hF00F, 4'd4,  OP_SRL, 16'h0F00, "srl_f00f_4");
        run(16'h1234, 4'd8,  OP_ROR, 16'h3412, "ror_1234_8");
        run(16'h8001, 4'd8,  OP_SLL, 16'h0100, "sll_8001_8");
    endtask

    task automatic test_cnt_zero();
        run(16'h8000, 4'd0, OP_SRL, 16'h8000, "srl_cnt0");
        run(16'hA5C3, 4'd0, OP_ROL, 16'hA5C3, "rol_cnt0");
    endtask

    task automatic test_busy_ignore();
        int pulses = 0;
        logic [15:0] res = '0;
        @(negedge clk); in_v = 16'h1234; cnt_v = 4'd5; op_v = OP_ROL; start = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); start = busy; in_v = 16'hFFFF; cnt_v = 4'd1; op_v = OP_SRL;
            @(posedge clk); #1;
            if (done) begin pulses++; res = out_v; end
        end
        start = 1'b0;
        checks++; if (pulses != 1) begin errors++; $display("FAIL busy_ignore_pulses got=%0d exp=1", pulses); end
        checks++; if (res !== 16'h4682) begin errors++; $display("FAIL busy_ignore_out got=%h exp=4682", res); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_ignore_not_queued got busy=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        @(negedge clk); in_v = 16'h00F0; cnt_v = 4'd15; op_v = OP_ROL; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before got=%b exp=1", busy); end
        rst = 1'b1; #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || out_v !== 16'h0)
            begin errors++; $display("FAIL rst_mid_clear got busy=%b done=%b out=%h exp 0 0 0000", busy, done, out_v); end
        @(negedge clk); rst = 1'b0;
        repeat (8) begin @(posedge clk); #1; if (done) pulses++; end
        checks++; if (pulses != 0) begin errors++; $display("FAIL rst_mid_no_done got=%0d exp=0", pulses); end
        run(16'h00F0, 4'd3, OP_ROL, 16'h0780, "after_rst");
    endtask

    initial begin
        test_reset();
        test_ops();
        test_cnt_zero();
        test_busy_ignore();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
